// File: rtl/drum_voice.sv
// drum_voice: triggered square-wave drum voice with downward pitch sweep and linear amplitude decay.
// Optional macro DRUM_VOICE_NOISE_EN adds an LFSR that scrambles the sample sign (snare-like).
module drum_voice #(
  parameter logic [15:0] PITCH_START = 16'd2400,
  parameter logic [15:0] PITCH_END   = 16'd300,
  parameter logic [15:0] PITCH_STEP  = 16'd40,
  parameter int          DECAY_SHIFT = 4
) (
  input  logic               audio_tick,
  input  logic               reset,
  input  logic               trigger,
  output logic signed [15:0] sample,
  output logic               active
);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state_q, state_d;
  logic [15:0] phase_q, phase_d, freq_q, freq_d;
  logic [7:0] amp_q, amp_d;
  logic signed [15:0] sample_q, sample_d, mag;
  logic play, step, sign;
  assign play = state_q == PLAY;
  generate
    if (DECAY_SHIFT == 0) begin : g_nodcnt
      assign step = 1'b1;
    end else begin : g_dcnt
      logic [DECAY_SHIFT-1:0] dcnt_q;
      always_ff @(posedge audio_tick or posedge reset)
        if (reset) dcnt_q <= '0;
        else dcnt_q <= trigger ? '0 : dcnt_q + DECAY_SHIFT'(play);
      assign step = &dcnt_q;
    end
  endgenerate
`ifdef DRUM_VOICE_NOISE_EN
  logic [14:0] lfsr_q;
  always_ff @(posedge audio_tick or posedge reset)
    if (reset) lfsr_q <= 15'h7FFF;
    else lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
  assign sign = phase_q[15] ^ lfsr_q[0];
`else
  assign sign = phase_q[15];
`endif
  always_ff @(posedge audio_tick or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      freq_q   <= PITCH_START;
      amp_q    <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      freq_q   <= freq_d;
      amp_q    <= amp_d;
      sample_q <= sample_d;
    end
  // trigger wins over the decay step that would otherwise end the note
  always_comb begin
    state_d = trigger ? PLAY : (play && step && amp_q == 8'd1) ? IDLE : state_q;
    phase_d = trigger ? '0 : play ? phase_q + freq_q : phase_q;
    amp_d   = trigger ? 8'd255 : (play && step) ? amp_q - 8'd1 : amp_q;
    freq_d  = trigger ? PITCH_START : !(play && step) ? freq_q :
              (freq_q <= PITCH_END + PITCH_STEP) ? PITCH_END : freq_q - PITCH_STEP;
  end
  always_comb begin
    mag      = {1'b0, amp_q, 7'd0};
    sample_d = play ? (sign ? -mag : mag) : '0;
  end
  assign sample = sample_q;
  assign active = play;
endmodule

// File: tb/tb_drum_voice.sv
// tb_drum_voice: scoreboard bench for two drum_voice instances (DECAY_SHIFT 4 and 0) against a note-level model.
module tb_drum_voice;
  localparam int S0 = 4;
  localparam int S1 = 0;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic trig0 = 1'b0;
  logic trig1 = 1'b0;
  logic signed [15:0] smp0, smp1;
  logic act0, act1;
  int checks = 0;
  int fails = 0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  drum_voice #(.DECAY_SHIFT(S0)) u0 (.audio_tick(clk), .reset(reset), .trigger(trig0), .sample(smp0), .active(act0));
  drum_voice #(.DECAY_SHIFT(S1)) u1 (.audio_tick(clk), .reset(reset), .trigger(trig1), .sample(smp1), .active(act1));

  always #5 clk = ~clk;

  // n = edges elapsed since the trigger edge (-1 when silent); amplitude and pitch follow from n directly
  function automatic int freq_of(input int steps);
    int f;
    f = 2400 - 40 * steps;
    return f < 300 ? 300 : f;
  endfunction

  function automatic logic [15:0] exp_smp(input int n, input logic [15:0] ph, input int s, input logic nz);
    int m;
    if (n < 0) return 16'd0;
    m = (255 - (n >> s)) * 128;
    return (ph[15] ^ nz) ? 16'(-m) : 16'(m);
  endfunction

  task automatic adv(input logic t, input int s, inout int n, inout logic [15:0] ph);
    if (t) begin
      n = 0;
      ph = 16'd0;
    end else if (n >= 0) begin
      ph = ph + 16'(freq_of(n >> s));
      n++;
      if ((n >> s) >= 255) n = -1;
    end
  endtask

  task automatic cmp(input string nm, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @%0t: sample=%0d active=%0b, expected sample=%0d active=%0b",
               nm, $time, $signed(got[16:1]), got[0], $signed(want[16:1]), want[0]);
    end
  endtask

  initial begin : model
    int n0, n1;
    logic [15:0] p0, p1, e0, e1;
    logic [14:0] lf;
    logic nz;
    n0 = -1; n1 = -1; p0 = '0; p1 = '0; lf = 15'h7FFF;
    forever begin
      @(posedge clk);
      if (reset) begin
        n0 = -1; n1 = -1; p0 = '0; p1 = '0; lf = 15'h7FFF;
        q0.push_back(17'd0);
        q1.push_back(17'd0);
      end else begin
`ifdef DRUM_VOICE_NOISE_EN
        nz = lf[0];
`else
        nz = 1'b0;
`endif
        e0 = exp_smp(n0, p0, S0, nz);
        e1 = exp_smp(n1, p1, S1, nz);
        adv(trig0, S0, n0, p0);
        adv(trig1, S1, n1, p1);
        q0.push_back({e0, n0 >= 0});
        q1.push_back({e1, n1 >= 0});
        lf = {lf[13:0], lf[14] ^ lf[13]};
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (q0.size() > 0) cmp("voice0", {smp0, act0}, q0.pop_front());
      else cmp("voice0_noexp", 17'd1, 17'd0);
      if (q1.size() > 0) cmp("voice1", {smp1, act1}, q1.pop_front());
      else cmp("voice1_noexp", 17'd1, 17'd0);
    end
  end

  task automatic tick(input logic a, input logic b);
    @(negedge clk);
    trig0 = a;
    trig1 = b;
  endtask

  task automatic async_rst();
    @(negedge clk);
    trig0 = 1'b0;
    trig1 = 1'b0;
    #2 reset = 1'b1;
    #1;
    cmp("async_reset0", {smp0, act0}, 17'd0);
    cmp("async_reset1", {smp1, act1}, 17'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : driver
    trig0 = 1'b1;
    trig1 = 1'b1;
    repeat (10) @(negedge clk);
    trig0 = 1'b0;
    trig1 = 1'b0;
    reset = 1'b0;
    tick(1'b1, 1'b1);
    repeat (99) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (254) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    repeat (4100) tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    repeat (50) tick(1'b0, 1'b0);
    async_rst();
    repeat (3000) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) async_rst();
    end
    tick(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
